// File: rtl/lbist_pkg.sv
// lbist_pkg: shared constants for the LBIST memory read path.
//   - default memory geometry (word width, address width, fail counter width)
//   - mem_seq FSM state encoding
package lbist_pkg;

    localparam int unsigned DEF_WORD_SIZE  = 8;
    localparam int unsigned DEF_ADDR_BITS  = 8;
    localparam int unsigned DEF_FAIL_CNT_W = 8;

    localparam int unsigned ST_W = 3;

    localparam logic [ST_W-1:0] ST_IDLE    = 3'd0;
    localparam logic [ST_W-1:0] ST_READ    = 3'd1;
    localparam logic [ST_W-1:0] ST_CAPTURE = 3'd2;
    localparam logic [ST_W-1:0] ST_HOLD    = 3'd3;
    localparam logic [ST_W-1:0] ST_DONE    = 3'd4;

endpackage

// File: rtl/mem_seq_addr_ctr.sv
// addr_ctr: loadable wrap-around address pointer for mem_seq.
//   clk, rst_n  : clock, asynchronous active-low reset
//   load        : load load_addr into count and latch last_addr
//   inc         : advance count by one, modulo 2^ADDR_BITS
//   load_addr   : first address of the range
//   last_addr   : final (inclusive) address of the range
//   count       : current address
//   at_last     : registered flag, count equals the latched last address
module addr_ctr
    import lbist_pkg::*;
#(
    parameter int unsigned ADDR_BITS = DEF_ADDR_BITS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic                 inc,
    input  logic [ADDR_BITS-1:0] load_addr,
    input  logic [ADDR_BITS-1:0] last_addr,
    output logic [ADDR_BITS-1:0] count,
    output logic                 at_last
);

    logic [ADDR_BITS-1:0] last_q;
    logic [ADDR_BITS-1:0] count_inc;

    // Natural overflow of the adder gives the wrap through zero.
    assign count_inc = count + ADDR_BITS'(1);

    // at_last is computed from the next count so it is ready in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count   <= '0;
            last_q  <= '0;
            at_last <= 1'b0;
        end else if (load) begin
            count   <= load_addr;
            last_q  <= last_addr;
            at_last <= (load_addr == last_addr);
        end else if (inc) begin
            count   <= count_inc;
            at_last <= (count_inc == last_q);
        end
    end

endmodule

// File: rtl/mem_seq.sv
// mem_seq: streams a contiguous, possibly wrapping, address range out of the
// LBIST word memory to a valid/ready consumer, one word per READ/CAPTURE/HOLD.
// Optional compare path: define MEM_SEQ_CMP_EN to check each handshaken word
// against exp_data; otherwise fail/fail_cnt are tied low and exp_data ignored.
//   start, abort          : run control from the BIST controller
//   base_addr, last_addr  : inclusive range, latched on an accepted start
//   mem_en, mem_rw, mem_add, mem_rdata : memory port (read only)
//   dout, dout_valid, dout_ready       : streamed word handshake
//   exp_data              : CUT response compared against dout
//   busy, done            : run in progress / one-cycle completion pulse
//   fail, fail_cnt        : sticky mismatch flag and saturating mismatch count
module mem_seq
    import lbist_pkg::*;
#(
    parameter int unsigned WORD_SIZE  = DEF_WORD_SIZE,
    parameter int unsigned ADDR_BITS  = DEF_ADDR_BITS,
    parameter int unsigned FAIL_CNT_W = DEF_FAIL_CNT_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_BITS-1:0]  base_addr,
    input  logic [ADDR_BITS-1:0]  last_addr,
    output logic                  mem_en,
    output logic                  mem_rw,
    output logic [ADDR_BITS-1:0]  mem_add,
    input  logic [WORD_SIZE-1:0]  mem_rdata,
    output logic [WORD_SIZE-1:0]  dout,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    input  logic [WORD_SIZE-1:0]  exp_data,
    output logic                  busy,
    output logic                  done,
    output logic                  fail,
    output logic [FAIL_CNT_W-1:0] fail_cnt
);

    logic [ST_W-1:0] state;
    logic [ST_W-1:0] state_nxt;
    logic            ld_c;
    logic            inc_c;
    logic            hs_c;
    logic            at_last;

    // Read only port.
    assign mem_rw = 1'b0;

    // A handshake that an abort in the same cycle cancels does not count.
    assign hs_c = (state == ST_HOLD) & dout_valid & dout_ready & ~abort;

    // The pointer register drives the memory address directly.
    addr_ctr #(
        .ADDR_BITS (ADDR_BITS)
    ) u_addr_ctr (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (ld_c),
        .inc       (inc_c),
        .load_addr (base_addr),
        .last_addr (last_addr),
        .count     (mem_add),
        .at_last   (at_last)
    );

    // Next-state and pointer control; abort overrides start and handshake.
    always_comb begin
        state_nxt = state;
        ld_c      = 1'b0;
        inc_c     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    ld_c      = 1'b1;
                    state_nxt = ST_READ;
                end
            end
            ST_READ:    state_nxt = ST_CAPTURE;
            ST_CAPTURE: state_nxt = ST_HOLD;
            ST_HOLD: begin
                if (hs_c) begin
                    if (at_last) begin
                        state_nxt = ST_DONE;
                    end else begin
                        inc_c     = 1'b1;
                        state_nxt = ST_READ;
                    end
                end
            end
            ST_DONE:    state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
        if (abort) begin
            state_nxt = ST_IDLE;
            ld_c      = 1'b0;
            inc_c     = 1'b0;
        end
    end

    // State and registered outputs, decoded from the next state so that each
    // output is valid in the cycle its state is occupied.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            mem_en     <= 1'b0;
            dout       <= '0;
            dout_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nxt;
            mem_en     <= (state_nxt == ST_READ);
            dout_valid <= (state_nxt == ST_HOLD);
            busy       <= (state_nxt != ST_IDLE);
            done       <= (state_nxt == ST_DONE);
            if ((state == ST_CAPTURE) && (state_nxt == ST_HOLD)) begin
                dout <= mem_rdata;
            end
        end
    end

`ifdef MEM_SEQ_CMP_EN
    // Verdict: cleared on an accepted start, updated once per handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail     <= 1'b0;
            fail_cnt <= '0;
        end else if (ld_c) begin
            fail     <= 1'b0;
            fail_cnt <= '0;
        end else if (hs_c && (dout != exp_data)) begin
            fail <= 1'b1;
            if (fail_cnt != {FAIL_CNT_W{1'b1}}) begin
                fail_cnt <= fail_cnt + FAIL_CNT_W'(1);
            end
        end
    end
`else
    logic unused_exp;

    assign fail       = 1'b0;
    assign fail_cnt   = '0;
    assign unused_exp = ^exp_data;
`endif

endmodule

// File: tb/tb_mem_seq.sv
// tb_mem_seq: scoreboard bench for mem_seq with a behavioural synchronous-read
// memory preloaded with mem[i] = i.
module tb_mem_seq;

    localparam int unsigned WS  = 8;
    localparam int unsigned AB  = 8;
    localparam int unsigned FCW = 2;
`ifdef MEM_SEQ_CMP_EN
    localparam bit CMP = 1'b1;
`else
    localparam bit CMP = 1'b0;
`endif

    logic           clk;
    logic           rst_n;
    logic           start;
    logic           abort;
    logic [AB-1:0]  base_addr;
    logic [AB-1:0]  last_addr;
    logic           mem_en;
    logic           mem_rw;
    logic [AB-1:0]  mem_add;
    logic [WS-1:0]  mem_rdata;
    logic [WS-1:0]  dout;
    logic           dout_valid;
    logic           dout_ready;
    logic [WS-1:0]  exp_data;
    logic           busy;
    logic           done;
    logic           fail;
    logic [FCW-1:0] fail_cnt;

    logic [WS-1:0]  mem_arr [256];
    logic [WS-1:0]  exp_q [$];

    int n_tests;
    int n_fail;
    int cyc;
    int hs_count;
    int run_base;
    int last_hs_cyc;
    int done_cnt;
    bit chk_gap;
    logic [31:0] flip_mask;
    logic          prev_valid;
    logic          prev_ready;
    logic [WS-1:0] prev_dout;

    mem_seq #(
        .WORD_SIZE  (WS),
        .ADDR_BITS  (AB),
        .FAIL_CNT_W (FCW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .base_addr  (base_addr),
        .last_addr  (last_addr),
        .mem_en     (mem_en),
        .mem_rw     (mem_rw),
        .mem_add    (mem_add),
        .mem_rdata  (mem_rdata),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .exp_data   (exp_data),
        .busy       (busy),
        .done       (done),
        .fail       (fail),
        .fail_cnt   (fail_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read memory: data appears the cycle after EN is sampled.
    always @(posedge clk) begin
        if (mem_en && !mem_rw) mem_rdata <= mem_arr[mem_add];
    end

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Monitor: scoreboard pops on handshake, plus protocol checks.
    always @(negedge clk) begin
        logic [WS-1:0] e;
        int idx;
        cyc++;
        if (!rst_n) begin
            prev_valid = 1'b0;
        end else begin
            if (done) begin
                done_cnt++;
                if (last_hs_cyc >= 0) check("done_lat", cyc - last_hs_cyc, 1);
            end
            if (prev_valid && prev_ready) check("no_dup", int'(dout_valid), 0);
            if (dout_valid) begin
                idx = hs_count - run_base;
                if (exp_q.size() > 0 && idx < 32)
                    exp_data = exp_q[0] ^ (flip_mask[idx] ? 8'hFF : 8'h00);
                check("en_hold", int'(mem_en), 0);
                if (prev_valid && !prev_ready) check("stable", int'(dout), int'(prev_dout));
                if (dout_ready) begin
                    if (exp_q.size() == 0) begin
                        check("extra_word", int'(dout_valid), 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("dout", int'(dout), int'(e));
                    end
                    if (chk_gap && last_hs_cyc >= 0) check("gap", cyc - last_hs_cyc, 3);
                    last_hs_cyc = cyc;
                    hs_count++;
                end
            end
            prev_valid = dout_valid;
            prev_ready = dout_ready;
            prev_dout  = dout;
        end
    end

    // Queue the expected words for [b..l] (wrapping) and pulse start once.
    task automatic start_run(input logic [AB-1:0] b, input logic [AB-1:0] l);
        logic [AB-1:0] a;
        a = b;
        for (int i = 0; i < 256; i++) begin
            exp_q.push_back(mem_arr[a]);
            if (a == l) break;
            a = a + 8'd1;
        end
        last_hs_cyc = -1;
        run_base    = hs_count;
        base_addr   = b;
        last_addr   = l;
        start       = 1'b1;
        @(posedge clk) #1;
        start       = 1'b0;
    endtask

    task automatic wait_done(input int bound, input string tag);
        int d0;
        d0 = done_cnt;
        for (int i = 0; i < bound && done_cnt == d0; i++) @(posedge clk) #1;
        check({tag, "_done"}, done_cnt - d0, 1);
        check({tag, "_left"}, exp_q.size(), 0);
        check({tag, "_busy"}, int'(busy), 0);
    endtask

    task automatic wait_valid(input int bound, input string tag);
        for (int i = 0; i < bound && !dout_valid; i++) @(posedge clk) #1;
        check({tag, "_valid_tmo"}, int'(dout_valid), 1);
    endtask

    initial begin
        int d0;
        n_tests = 0; n_fail = 0; cyc = 0; hs_count = 0; run_base = 0;
        last_hs_cyc = -1; done_cnt = 0; chk_gap = 1'b0; flip_mask = '0;
        prev_valid = 1'b0; prev_ready = 1'b0; prev_dout = '0;
        for (int i = 0; i < 256; i++) mem_arr[i] = 8'(i);
        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        base_addr = '0; last_addr = '0; dout_ready = 1'b1; exp_data = '0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_en",   int'(mem_en), 0);
        check("rst_rw",   int'(mem_rw), 0);
        check("rst_add",  int'(mem_add), 0);
        check("rst_dout", int'(dout), 0);
        check("rst_vld",  int'(dout_valid), 0);
        check("rst_fail", int'(fail), 0);
        check("rst_fcnt", int'(fail_cnt), 0);
        rst_n = 1'b1;
        @(posedge clk) #1;

        // Basic range 0x10..0x13 with latency and 3-cycle spacing
        chk_gap = 1'b1;
        start_run(8'h10, 8'h13);
        check("lat_busy", int'(busy), 1);
        check("lat_en",   int'(mem_en), 1);
        check("lat_add",  int'(mem_add), 'h10);
        check("lat_rw",   int'(mem_rw), 0);
        @(posedge clk) #1;
        check("lat_cap_en",  int'(mem_en), 0);
        check("lat_cap_vld", int'(dout_valid), 0);
        @(posedge clk) #1;
        check("lat_hold_vld", int'(dout_valid), 1);
        wait_done(60, "basic");
        check("basic_words", hs_count - run_base, 4);

        // Wrap FE, FF, 00, 01
        start_run(8'hFE, 8'h01);
        wait_done(60, "wrap");
        check("wrap_words", hs_count - run_base, 4);

        // Single word
        start_run(8'h33, 8'h33);
        wait_done(30, "single");
        check("single_words", hs_count - run_base, 1);
        chk_gap = 1'b0;

        // Backpressure on word 2
        start_run(8'h20, 8'h23);
        for (int i = 0; i < 30 && hs_count == run_base; i++) @(posedge clk) #1;
        check("bp_first_tmo", hs_count - run_base, 1);
        dout_ready = 1'b0;
        wait_valid(10, "bp");
        repeat (5) @(posedge clk) #1;
        check("bp_stall_vld", int'(dout_valid), 1);
        check("bp_stall_words", hs_count - run_base, 1);
        dout_ready = 1'b1;
        wait_done(60, "bp");
        check("bp_words", hs_count - run_base, 4);

        // Abort during CAPTURE of word 1
        d0 = done_cnt;
        start_run(8'h30, 8'h33);
        @(posedge clk) #1;
        check("ab_cap_en", int'(mem_en), 0);
        abort = 1'b1;
        @(posedge clk) #1;
        abort = 1'b0;
        check("ab_busy", int'(busy), 0);
        check("ab_vld",  int'(dout_valid), 0);
        check("ab_en",   int'(mem_en), 0);
        exp_q.delete();
        repeat (4) @(posedge clk) #1;
        check("ab_nodone", done_cnt - d0, 0);
        check("ab_words",  hs_count - run_base, 0);
        start_run(8'h40, 8'h41);
        wait_done(30, "ab_restart");

        // Compare: two of four words differ
        flip_mask = 32'h0000_000A;
        start_run(8'h50, 8'h53);
        wait_done(60, "cmp2");
        check("cmp2_fail", int'(fail), CMP ? 1 : 0);
        check("cmp2_fcnt", int'(fail_cnt), CMP ? 2 : 0);

        // Compare: five mismatches saturate a 2-bit count
        flip_mask = 32'hFFFF_FFFF;
        start_run(8'h60, 8'h64);
        check("clr_fail", int'(fail), 0);
        check("clr_fcnt", int'(fail_cnt), 0);
        wait_done(60, "cmp5");
        check("cmp5_fail", int'(fail), CMP ? 1 : 0);
        check("cmp5_fcnt", int'(fail_cnt), CMP ? 3 : 0);
        flip_mask = '0;

        // Asynchronous reset while stalled in HOLD
        dout_ready = 1'b0;
        start_run(8'h70, 8'h73);
        wait_valid(10, "ar");
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_busy", int'(busy), 0);
        check("ar_done", int'(done), 0);
        check("ar_en",   int'(mem_en), 0);
        check("ar_add",  int'(mem_add), 0);
        check("ar_dout", int'(dout), 0);
        check("ar_vld",  int'(dout_valid), 0);
        check("ar_fail", int'(fail), 0);
        check("ar_fcnt", int'(fail_cnt), 0);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
        dout_ready = 1'b1;
        @(posedge clk) #1;
        start_run(8'h05, 8'h06);
        wait_done(30, "post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_seq.md
# mem_seq

Read sequencer for the LBIST word memory. It streams a contiguous address range from a `mem` instance (deterministic patterns or fault-free responses) to a downstream consumer over a valid/ready handshake. It owns the memory's `EN`/`RW`/`add` pins and sits between the BIST top-level controller and the pattern applicator or ORA. An optional compare path checks each streamed word against the CUT response and accumulates a pass/fail verdict.

## Interface
- `WORD_SIZE`, 8, memory word width
- `ADDR_BITS`, 8, memory address width
- `FAIL_CNT_W`, 8, mismatch counter width
- `clk` in 1: rising-edge clock, shared with `mem`
- `rst_n` in 1: asynchronous active-low reset
- `start` in 1: begin a run; sampled only in IDLE
- `abort` in 1: terminate the run
- `base_addr` in ADDR_BITS: first address; latched on accepted `start`
- `last_addr` in ADDR_BITS: final address, inclusive; latched on accepted `start`
- `mem_en` out 1: to mem `EN`
- `mem_rw` out 1: to mem `RW`; constant 0 (read only)
- `mem_add` out ADDR_BITS: to mem `add`
- `mem_rdata` in WORD_SIZE: mem `data` net
- `dout` out WORD_SIZE: streamed word
- `dout_valid` out 1: `dout` is valid
- `dout_ready` in 1: consumer accepts the word
- `exp_data` in WORD_SIZE: CUT response compared with `dout`
- `busy` out 1: a run is in progress (state not IDLE)
- `done` out 1: one-cycle pulse at run completion
- `fail` out 1: sticky flag, any mismatch this run
- `fail_cnt` out FAIL_CNT_W: saturating mismatch count

## Operation
- States: IDLE, READ, CAPTURE, HOLD, DONE.
- **IDLE**
  - `start`=1 latches `base_addr`/`last_addr`, sets `ptr`=`base_addr`, clears `fail`/`fail_cnt`, then moves to READ.
- **READ**
  - `mem_en`=1, `mem_add`=`ptr`, then CAPTURE.
  - `mem_en` is 0 in all other states.
- **CAPTURE**
  - `dout` <= `mem_rdata`, `dout_valid` <= 1, then HOLD.
- **HOLD**
  - `dout` is held stable while `dout_valid`=1 and `dout_ready`=0.
  - On handshake (`dout_valid` and `dout_ready`), `dout_valid` <= 0.
  - If `ptr`==`last_addr`, go to DONE. Otherwise `ptr` <= `ptr`+1 mod 2^ADDR_BITS and go to READ.
- **DONE**
  - `done`=1 for this one cycle, then IDLE.
- **Range rules**
  - `last_addr` < `base_addr` wraps through 2^ADDR_BITS−1 to 0.
  - `base_addr`==`last_addr` gives exactly one word.
  - Words per run = ((`last_addr` − `base_addr`) mod 2^ADDR_BITS) + 1.
- **Abort**
  - `abort`=1 in any non-IDLE state goes to IDLE at the next edge and clears `dout_valid`.
  - No `done` pulse is produced; `fail`/`fail_cnt` are retained.
  - `abort` has priority over `start` and over the handshake.
- `start` outside IDLE is ignored.

## Timing
- Reset values:
  - state IDLE
  - `mem_en`=0, `mem_rw`=0, `mem_add`=0
  - `dout`=0, `dout_valid`=0
  - `busy`=0, `done`=0
  - `fail`=0, `fail_cnt`=0
- Latency:
  - `start` sampled at edge k; READ in cycle k+1; `mem_rdata` valid in cycle k+2; `dout_valid`=1 from cycle k+3.
  - With `dout_ready` tied to 1, throughput is one word per 3 cycles.
  - `done` is asserted in the cycle after the last handshake.
- `start` coinciding with `done` is not accepted; it is sampled again in the following IDLE cycle.

## Configuration
- **`MEM_SEQ_CMP_EN` defined**
  - At each handshake, `dout` != `exp_data` sets `fail` and increments `fail_cnt`.
  - `fail_cnt` saturates at 2^FAIL_CNT_W−1.
- **`MEM_SEQ_CMP_EN` undefined**
  - The compare logic is absent; `fail` and `fail_cnt` are tied to 0.
  - `exp_data` is ignored.
  - Ports are unchanged in both builds, so instantiations stay stable.

## Structure
- Shared package `lbist_pkg` holds:
  - the state encoding localparams (IDLE=0, READ=1, CAPTURE=2, HOLD=3, DONE=4)
  - the default `WORD_SIZE`/`ADDR_BITS`
- Sub-module `addr_ctr`: loadable ADDR_BITS wrap-around counter with `load`, `inc`, and a registered `at_last` compare against the latched `last_addr`.

## Test plan
- mem preloaded with mem[i]=i, range base=0x10, last=0x13, `dout_ready`=1 → `dout` 0x10..0x13 each valid one cycle, 3 cycles apart; `done` pulses once; `busy` falls.
- Wrap: base=0xFE, last=0x01 → words at addresses FE, FF, 00, 01, in that order, then `done`.
- Backpressure: `dout_ready`=0 for 5 cycles on word 2 → `dout` stable and `mem_en`=0 throughout; no words lost or duplicated.
- `abort` asserted during CAPTURE of word 1 → IDLE next cycle, `dout_valid`=0, no `done`; a new `start` then streams correctly.
- Compare (`MEM_SEQ_CMP_EN`): `exp_data` differs on 2 of 4 words → `fail`=1, `fail_cnt`=2; with FAIL_CNT_W=2 and 5 mismatches, `fail_cnt`=3.
- Async reset mid-run in HOLD → all outputs return to reset values immediately, without waiting for a clock edge.
